// File: rtl/otp_ctrl_pkg.sv
// Shared OTP controller constants and types for the EDN entropy arbiter.
// Sparse state codes keep every pair of legal states at Hamming distance >= 3.
package otp_ctrl_pkg;

    localparam int EdnWordWidth = 32;
    localparam int EdnDataWidth = 64;

    localparam int EdnClientTimer  = 0;
    localparam int EdnClientScrmbl = 1;

    typedef enum logic [4:0] {
        IdleSt  = 5'b00111,
        FetchSt = 5'b11001,
        AckSt   = 5'b11110,
        ErrorSt = 5'b00000
    } edn_arb_state_e;

endpackage

// File: rtl/otp_ctrl_edn_pack.sv
// Packs consecutive EDN words into one wide word, first word in the LSBs.
// Latency: done_o is combinational with the final ack; no backpressure (ack_i is a strobe).
module otp_ctrl_edn_pack #(
    parameter int EdnWordWidth = 32,
    parameter int OutWidth     = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    ack_i,
    input  logic [EdnWordWidth-1:0] word_i,
    output logic                    done_o,
    output logic [OutWidth-1:0]     data_o
);

    localparam int WordsPerReq = OutWidth / EdnWordWidth;
    localparam int CntWidth    = $clog2(WordsPerReq + 1);

    logic [CntWidth-1:0] cnt_q;
    logic [OutWidth-1:0] data_q;
    logic [OutWidth-1:0] data_shift;

    // Shifting down from the top leaves word 0 in the LSBs once all words are in.
    if (WordsPerReq > 1) begin : g_shift
        assign data_shift = {word_i, data_q[OutWidth-1:EdnWordWidth]};
    end else begin : g_single
        assign data_shift = word_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else if (ack_i) begin
            cnt_q  <= cnt_q + 1'b1;
            data_q <= data_shift;
        end
    end

    assign done_o = ack_i && (cnt_q == CntWidth'(WordsPerReq - 1));
    assign data_o = data_q;

endmodule

// File: rtl/otp_ctrl_edn_arb.sv
// Round-robin EDN entropy arbiter; request to ack = 2 + OutWidth/EdnWordWidth + EDN stall cycles.
// Requests wait while a fetch is in flight; OTP_CTRL_EDN_FIPS_CHK_EN enables FIPS-flag refetch.
module otp_ctrl_edn_arb
    import otp_ctrl_pkg::*;
#(
    parameter int NumClients   = 2,
    parameter int EdnWordWidth = otp_ctrl_pkg::EdnWordWidth,
    parameter int OutWidth     = otp_ctrl_pkg::EdnDataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumClients-1:0]   client_req_i,
    output logic [NumClients-1:0]   client_ack_o,
    output logic [OutWidth-1:0]     client_data_o,
    output logic                    edn_req_o,
    input  logic                    edn_ack_i,
    input  logic [EdnWordWidth-1:0] edn_bus_i,
    input  logic                    edn_fips_i,
    output logic                    busy_o,
    output logic                    fsm_err_o
);

    localparam int GrantWidth = (NumClients > 1) ? $clog2(NumClients) : 1;

    edn_arb_state_e        state_q, state_d;
    logic [GrantWidth-1:0] grant_q, grant_d;
    logic [GrantWidth-1:0] rr_q, rr_d;

    logic                pack_clr;
    logic                pack_ack;
    logic                pack_done;
    logic [OutWidth-1:0] pack_data;
    logic                fips_fail;
    logic                refetch_last;

    function automatic logic [GrantWidth-1:0] rr_pick(input logic [NumClients-1:0] req,
                                                      input logic [GrantWidth-1:0] ptr);
        logic [GrantWidth-1:0] sel;
        logic                  found;
        int                    idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NumClients; k++) begin
            idx = (int'(ptr) + k) % NumClients;
            if (!found && req[idx]) begin
                sel   = GrantWidth'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pack_ack = edn_ack_i && (state_q == FetchSt);

    otp_ctrl_edn_pack #(
        .EdnWordWidth(EdnWordWidth),
        .OutWidth    (OutWidth)
    ) u_pack (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (pack_clr),
        .ack_i (pack_ack),
        .word_i(edn_bus_i),
        .done_o(pack_done),
        .data_o(pack_data)
    );

`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
    logic       fips_q;
    logic [7:0] refetch_q;

    // The current word's flag is folded in directly so the final word counts.
    assign fips_fail    = ~(fips_q & edn_fips_i);
    assign refetch_last = (refetch_q == 8'd254);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fips_q <= 1'b1;
        end else if (pack_clr) begin
            fips_q <= 1'b1;
        end else if (pack_ack) begin
            fips_q <= fips_q & edn_fips_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            refetch_q <= '0;
        end else if (state_q == IdleSt) begin
            refetch_q <= '0;
        end else if (pack_done && fips_fail && (refetch_q != 8'hff)) begin
            refetch_q <= refetch_q + 8'd1;
        end
    end
`else
    logic unused_fips;
    assign unused_fips  = ^edn_fips_i;
    assign fips_fail    = 1'b0;
    assign refetch_last = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_d         = rr_q;
        pack_clr     = 1'b0;
        edn_req_o    = 1'b0;
        client_ack_o = '0;
        busy_o       = 1'b1;
        fsm_err_o    = 1'b0;

        unique case (state_q)
            IdleSt: begin
                busy_o = 1'b0;
                if (|client_req_i) begin
                    grant_d  = rr_pick(client_req_i, rr_q);
                    pack_clr = 1'b1;
                    state_d  = FetchSt;
                end
            end
            FetchSt: begin
                edn_req_o = 1'b1;
                if (pack_done) begin
                    if (fips_fail) begin
                        pack_clr = 1'b1;
                        if (refetch_last) begin
                            state_d = ErrorSt;
                        end
                    end else begin
                        state_d = AckSt;
                    end
                end
            end
            AckSt: begin
                // A withdrawn request silently drops the packed word.
                client_ack_o[grant_q] = client_req_i[grant_q];
                rr_d    = (grant_q == GrantWidth'(NumClients - 1)) ? '0 : grant_q + 1'b1;
                state_d = IdleSt;
            end
            ErrorSt: begin
                fsm_err_o = 1'b1;
            end
            default: begin
                fsm_err_o = 1'b1;
                state_d   = ErrorSt;
            end
        endcase
    end

    assign client_data_o = (|client_ack_o) ? pack_data : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IdleSt;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_otp_ctrl_edn_arb.sv
// Self-checking bench for otp_ctrl_edn_arb: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_otp_ctrl_edn_arb;
    import otp_ctrl_pkg::*;

    localparam int N  = 2;
    localparam int WW = EdnWordWidth;
    localparam int OW = EdnDataWidth;
    localparam int W  = OW / WW;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [N-1:0]  client_req_i = '0;
    logic [N-1:0]  client_ack_o;
    logic [OW-1:0] client_data_o;
    logic          edn_req_o;
    logic          edn_ack_i = 1'b0;
    logic [WW-1:0] edn_bus_i = '0;
    logic          edn_fips_i = 1'b0;
    logic          busy_o;
    logic          fsm_err_o;

    otp_ctrl_edn_arb dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .client_req_i (client_req_i),
        .client_ack_o (client_ack_o),
        .client_data_o(client_data_o),
        .edn_req_o    (edn_req_o),
        .edn_ack_i    (edn_ack_i),
        .edn_bus_i    (edn_bus_i),
        .edn_fips_i   (edn_fips_i),
        .busy_o       (busy_o),
        .fsm_err_o    (fsm_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Reference model: phase of the current transfer plus the words it has consumed.
    typedef enum int {M_IDLE, M_FETCH, M_ACK, M_ERR} mphase_e;
    mphase_e       m_ph = M_IDLE;
    int            m_grant = 0;
    int            m_rr = 0;
    logic [WW-1:0] m_words[$];
    logic [OW-1:0] m_data = '0;
`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
    bit            m_fips_ok = 1'b1;
    int            m_refetch = 0;
`endif

    // Bench-side client and EDN behaviour.
    logic [N-1:0]  pend = '0;
    bit            prev_req = 1'b0;
    int            gap = 0;
    int            stall = 0;
    bit            rand_edn = 1'b0;
    logic [WW-1:0] wq[$];
    bit            fq[$];
    int            n_acks = 0;
    int            n_req_hi = 0;

    logic [N-1:0]  s_ack;
    logic [OW-1:0] s_data;
    logic          s_busy;
    logic          s_req;
    logic          s_err;

    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [OW-1:0] pack_words();
        logic [OW-1:0] d = '0;
        foreach (m_words[k]) d[k*WW +: WW] = m_words[k];
        return d;
    endfunction

    task automatic model_check();
        logic [N-1:0]  e_ack;
        logic [OW-1:0] e_data;
        e_ack = '0;
        if (m_ph == M_ACK && client_req_i[m_grant]) e_ack[m_grant] = 1'b1;
        e_data = (e_ack != '0) ? m_data : '0;
        chk("ack", client_ack_o, e_ack);
        chk("data", client_data_o, e_data);
        chk("edn_req", edn_req_o, m_ph == M_FETCH);
        chk("busy", busy_o, m_ph != M_IDLE);
        chk("fsm_err", fsm_err_o, m_ph == M_ERR);
        case (m_ph)
            M_IDLE: begin
                if (client_req_i != '0) begin
                    m_grant = rr_pick(client_req_i, m_rr);
                    m_words.delete();
`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
                    m_fips_ok = 1'b1;
                    m_refetch = 0;
`endif
                    m_ph = M_FETCH;
                end
            end
            M_FETCH: begin
                if (edn_ack_i) begin
                    m_words.push_back(edn_bus_i);
`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
                    m_fips_ok = m_fips_ok & edn_fips_i;
`endif
                    if (m_words.size() == W) begin
`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
                        if (!m_fips_ok) begin
                            m_refetch++;
                            m_words.delete();
                            m_fips_ok = 1'b1;
                            if (m_refetch >= 255) m_ph = M_ERR;
                        end else
`endif
                        begin
                            m_data = pack_words();
                            m_ph   = M_ACK;
                        end
                    end
                end
            end
            M_ACK: begin
                m_rr = (m_grant + 1) % N;
                m_ph = M_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        client_req_i = pend;
        if (edn_req_o && prev_req && stall == 0) begin
            edn_ack_i  = 1'b1;
            edn_bus_i  = (wq.size() > 0) ? wq.pop_front() : WW'($urandom);
            edn_fips_i = (fq.size() > 0) ? fq.pop_front()
                                         : (rand_edn ? ($urandom_range(0, 5) != 0) : 1'b1);
            stall      = rand_edn ? $urandom_range(0, 2) : gap;
        end else begin
            edn_ack_i  = 1'b0;
            edn_bus_i  = WW'($urandom);
            edn_fips_i = 1'($urandom_range(0, 1));
            if (edn_req_o && prev_req && stall > 0) stall--;
        end
        @(negedge clk_i);
        model_check();
        s_ack  = client_ack_o;
        s_data = client_data_o;
        s_busy = busy_o;
        s_req  = edn_req_o;
        s_err  = fsm_err_o;
        if (s_ack != '0) n_acks++;
        if (s_req) n_req_hi++;
        prev_req = edn_req_o;
        pend     = pend & ~client_ack_o;
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        pend         = '0;
        client_req_i = '0;
        edn_ack_i    = 1'b0;
        edn_bus_i    = '0;
        edn_fips_i   = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ack", client_ack_o, '0);
        chk("rst_data", client_data_o, '0);
        chk("rst_edn_req", edn_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", fsm_err_o, 1'b0);
        m_ph     = M_IDLE;
        m_rr     = 0;
        m_grant  = 0;
        prev_req = 1'b0;
        stall    = 0;
        wq.delete();
        fq.delete();
        rst_ni = 1'b1;
    endtask

    task automatic wait_ack(input int max, output int idx, output int lat);
        idx = -1;
        lat = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (s_ack != '0) begin
                for (int k = 0; k < N; k++) if (s_ack[k]) idx = k;
                lat = i;
                break;
            end
        end
        if (idx < 0) chk("ack_timeout", 0, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, lat, base, cnt;
        logic b4, b5;

        do_reset();

        // Single request, EDN acking back to back.
        wq   = '{32'h11111111, 32'h22222222};
        pend = 2'b01;
        wait_ack(20, idx, lat);
        chk("single_idx", idx, EdnClientTimer);
        chk("single_lat", lat, 4);
        chk("single_data", s_data, 64'h2222222211111111);
        repeat (2) tick();

        // Contention, then an immediate re-request by the client just served.
        do_reset();
        pend = 2'b11;
        wait_ack(20, idx, lat);
        chk("cont0_idx", idx, EdnClientTimer);
        chk("cont0_lat", lat, 4);
        pend[0] = 1'b1;
        wait_ack(20, idx, lat);
        chk("cont1_idx", idx, EdnClientScrmbl);
        chk("cont1_lat", lat, 4);
        wait_ack(20, idx, lat);
        chk("cont2_idx", idx, EdnClientTimer);

        // Five idle EDN cycles between the two words.
        gap   = 5;
        stall = 0;
        pend  = 2'b01;
        base  = n_req_hi;
        wait_ack(40, idx, lat);
        chk("stall_lat", lat, 9);
        chk("stall_req_cycles", n_req_hi - base, 8);
        gap   = 0;
        stall = 0;

        // Client 1 withdraws during the fetch.
        pend = 2'b10;
        cnt  = 0;
        b4   = 1'b0;
        b5   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) pend[1] = 1'b0;
            if (s_ack != '0) cnt++;
            if (i == 4) b4 = s_busy;
            if (i == 5) b5 = s_busy;
        end
        chk("wd_no_ack", cnt, 0);
        chk("wd_busy_ack", b4, 1'b1);
        chk("wd_busy_after", b5, 1'b0);

        // FIPS flag low on word 1 of the first transfer.
        wq   = '{32'hA5A50001, 32'hA5A50002, 32'hA5A50003, 32'hA5A50004};
        fq   = '{1'b1, 1'b0, 1'b1, 1'b1};
        pend = 2'b01;
        wait_ack(30, idx, lat);
`ifdef OTP_CTRL_EDN_FIPS_CHK_EN
        chk("fips_lat", lat, 6);
        chk("fips_data", s_data, 64'hA5A50004A5A50003);
`else
        chk("fips_lat", lat, 4);
        chk("fips_data", s_data, 64'hA5A50002A5A50001);
`endif
        wq.delete();
        fq.delete();
        tick();

        // Random traffic with random EDN stalls, words and FIPS flags.
        rand_edn = 1'b1;
        base     = n_acks;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 3) == 0) pend[k] = 1'b1;
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[k] = 1'b0;
                end
            end
            tick();
        end
        rand_edn = 1'b0;
        chk("rand_enough_acks", (n_acks - base) > 50, 1'b1);

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        pend = 2'b01;
        repeat (3) tick();
        @(posedge clk_i);
        #2;
        rst_ni    = 1'b0;
        edn_ack_i = 1'b0;
        #1;
        chk("arst_ack", client_ack_o, '0);
        chk("arst_data", client_data_o, '0);
        chk("arst_edn_req", edn_req_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_err", fsm_err_o, 1'b0);
        do_reset();
        wq   = '{32'hCAFE0001, 32'hCAFE0002};
        pend = 2'b01;
        wait_ack(20, idx, lat);
        chk("arst_retry_lat", lat, 4);
        chk("arst_retry_data", s_data, 64'hCAFE0002CAFE0001);
        tick();

        // Illegal state encoding.
        pend = 2'b11;
        force dut.state_q = edn_arb_state_e'(5'b10101);
        m_ph = M_ERR;
        tick();
        release dut.state_q;
        base = n_req_hi;
        repeat (10) tick();
        chk("fault_err", s_err, 1'b1);
        chk("fault_no_edn_req", n_req_hi - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/otp_ctrl_edn_arb.md
Name: otp_ctrl_edn_arb

Overview:
- Upstream entropy stage for the OTP controller.
- Arbitrates EDN entropy requests from several internal consumers, such as the LFSR check timer reseed and the scrambling key-derivation datapath.
- Fetches 32-bit words from the single EDN port and packs them into one wide word per grant.
- Returns the packed word with a one-cycle ack to the granted client.

Parameters:
- NumClients, 2, number of requesting consumers; index 0 is the check timer.
- EdnWordWidth, 32, width of one EDN bus word.
- OutWidth, 64, width of the packed word delivered to clients; must be an integer multiple of EdnWordWidth.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- client_req_i  in  NumClients  level request per client; held until acked
- client_ack_o  out  NumClients  one-cycle ack, at most one bit set
- client_data_o  out  OutWidth  packed entropy, shared bus; valid only while an ack bit is high
- edn_req_o  out  1  request to EDN
- edn_ack_i  in  1  EDN word valid
- edn_bus_i  in  EdnWordWidth  EDN word
- edn_fips_i  in  1  FIPS flag of the current EDN word
- busy_o  out  1  high while not in IdleSt
- fsm_err_o  out  1  invalid-state indication

Behaviour:
- Constant: WordsPerReq = OutWidth/EdnWordWidth. Counter width: $clog2(WordsPerReq+1).
- Reset values: client_ack_o=0, client_data_o=0, edn_req_o=0, busy_o=0, fsm_err_o=0. Packing register, word counter and grant index are all 0. Round-robin pointer is 0.
- FSM uses a sparse encoding (minimum Hamming distance 3) with states IdleSt, FetchSt, AckSt, ErrorSt.
- IdleSt:
  - If any client_req_i is set, latch grant = first set request at or above the round-robin pointer (wrapping).
  - Clear the word counter and go to FetchSt the next cycle.
  - No requests: stay in IdleSt.
- FetchSt:
  - edn_req_o=1.
  - On each edn_ack_i, shift edn_bus_i into the packing register. The first word lands in the LSBs: word k occupies bits [k*EdnWordWidth +: EdnWordWidth].
  - Increment the counter on each ack.
  - When the counter reaches WordsPerReq-1 and edn_ack_i=1, go to AckSt. edn_req_o drops in the cycle after the final ack.
- AckSt: lasts exactly one cycle.
  - client_ack_o[grant]=1 only if client_req_i[grant] is still high; client_data_o = packed register.
  - If the client dropped its request, the data is discarded and no ack is issued.
  - Round-robin pointer becomes grant+1, wrapping to 0 at NumClients.
  - Return to IdleSt.
- Latency:
  - Request to ack = 2 + WordsPerReq + EDN stall cycles.
  - With EDN acking every cycle and WordsPerReq=2: request at cycle 0, ack at cycle 4.
- Back-to-back: a client may re-request in the cycle after its ack. Another pending client is served first under the round-robin rule.
- Requests arriving during FetchSt or AckSt wait; they are never lost.
- client_data_o is driven to 0 whenever no ack is high, so no entropy leaks on the shared bus.
- Invalid state encoding: go to ErrorSt with fsm_err_o=1.
- ErrorSt is terminal: edn_req_o=0, no acks, fsm_err_o=1 every cycle.
- Asynchronous reset mid-fetch: immediate return to reset values; partially packed words are dropped.

Optional Feature:
- Macro: OTP_CTRL_EDN_FIPS_CHK_EN.
- Defined:
  - A sticky per-transfer flag is ANDed with edn_fips_i over all words of the transfer.
  - If the flag is 0 at the end of FetchSt, discard the packed word, clear the counter and re-enter FetchSt with the same grant. No ack is issued.
  - An 8-bit saturating counter counts refetches; when it saturates at 255, go to ErrorSt.
- Undefined: edn_fips_i is ignored (xor-reduced into an unused signal) and no refetch occurs.

Decomposition:
- Add to otp_ctrl_pkg:
  - EdnWordWidth constant.
  - Existing EdnDataWidth as the default for OutWidth.
  - edn_arb_state_e encoding.
  - Client index localparams: EdnClientTimer=0, EdnClientScrmbl=1.
- Sub-module otp_ctrl_edn_pack holds the shift/pack register and word counter, with ports for clear, ack, word in, done and data out. The arbiter FSM stays in the top.

Test Plan:
- Single request: client 0 requests, EDN acks words 0x11111111 then 0x22222222 on consecutive cycles -> ack on client 0 at cycle 4 with data 0x2222222211111111; client_data_o is 0 in all other cycles.
- Contention: both clients request at cycle 0 -> client 0 acked first, then client 1. Both request again -> client 1 is acked first on that round.
- EDN stall: insert 5 idle cycles between EDN acks -> ack delayed by exactly 5 cycles; edn_req_o stays high throughout FetchSt.
- Request withdrawal: client 1 drops its request during FetchSt -> no ack is issued, FSM returns to IdleSt, busy_o=0 one cycle after AckSt.
- FIPS (macro on): first transfer has edn_fips_i=0 on word 1 -> refetch of two more words, then a single ack carrying the new data. Macro off -> ack with the original data.
- Fault and reset: force an invalid state -> fsm_err_o=1, no further edn_req_o. Assert rst_ni mid-FetchSt -> all outputs 0 immediately.
